// File: rtl/adc_serial_rx_mc.sv
// adc_serial_rx_mc: synchronous TDM frame receiver for delta-sigma ADC serial pins with tagged FWFT output FIFO
module adc_serial_rx_mc #(
  parameter int DW = 24,
  parameter int SW = 32,
  parameter int CH = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           sck,
  input  logic           fsync,
  input  logic           din,
  output logic [DW-1:0]  m_data,
  output logic [CHW-1:0] m_ch,
  output logic           m_valid,
  input  logic           m_ready,
  output logic           overflow,
  output logic           frame_err,
  output logic           start,
  output logic           pd,
  output logic           cs_n
);
  localparam int BW = (SW > 1) ? $clog2(SW) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DW + CHW;
  localparam logic IDLE = 1'b0;
  localparam logic SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] sck_sync_q, fs_sync_q, din_sync_q;
  logic sck_h_q, sck_re_q, fs_q, din_q, fs_prev_q, fs_prev_d, fs_edge;
  logic state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [CHW-1:0] slot_q, slot_d;
  logic [DW-1:0] sh_q, sh_d, sh_nx;
  logic push_q, push_d, ferr_q, ferr_d;
  logic [WW-1:0] pdata_q, pdata_d;
  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic empty, full, pop, wr;

  // pins are re-registered once after the synchroniser so sck_re, fsync and din stay cycle-aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q <= '0;
      fs_sync_q <= '0;
      din_sync_q <= '0;
      sck_h_q <= 1'b0;
      sck_re_q <= 1'b0;
      fs_q <= 1'b0;
      din_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      fs_sync_q <= {fs_sync_q[SYNC_STAGES-2:0], fsync};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
      sck_h_q <= sck_sync_q[SYNC_STAGES-1];
      sck_re_q <= sck_sync_q[SYNC_STAGES-1] & ~sck_h_q;
      fs_q <= fs_sync_q[SYNC_STAGES-1];
      din_q <= din_sync_q[SYNC_STAGES-1];
    end
  end

  assign fs_edge = sck_re_q & fs_q & ~fs_prev_q;
  assign fs_prev_d = sck_re_q ? fs_q : fs_prev_q;
  assign sh_nx = (32'(cnt_q) < DW) ? {sh_q[DW-2:0], din_q} : sh_q;
  assign pdata_d = {slot_q, sh_nx};

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    slot_d = slot_q;
    sh_d = sh_q;
    push_d = 1'b0;
    ferr_d = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d = '0;
      slot_d = '0;
    end else if (fs_edge) begin
      state_d = SHIFT;
      cnt_d = BW'(1);
      slot_d = '0;
      sh_d = {sh_q[DW-2:0], din_q};
      ferr_d = (state_q == SHIFT);
    end else if (sck_re_q && state_q == SHIFT) begin
      sh_d = sh_nx;
      if (cnt_q == BW'(SW - 1)) begin
        push_d = 1'b1;
        cnt_d = '0;
        slot_d = (slot_q == CHW'(CH - 1)) ? '0 : slot_q + CHW'(1);
        state_d = (slot_q == CHW'(CH - 1)) ? IDLE : SHIFT;
      end else begin
        cnt_d = cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fs_prev_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      slot_q <= '0;
      sh_q <= '0;
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      pdata_q <= '0;
    end else begin
      fs_prev_q <= fs_prev_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      slot_q <= slot_d;
      sh_q <= sh_d;
      push_q <= push_d;
      ferr_q <= ferr_d;
      pdata_q <= pdata_d;
    end
  end

  assign empty = (wr_q == rd_q);
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop = ~empty & m_ready;
  assign wr = push_q & (~full | pop);
  assign wr_d = wr_q + {{AW{1'b0}}, wr};
  assign rd_d = rd_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (wr) mem_q[wr_q[AW-1:0]] <= pdata_q;
    end
  end

  assign m_valid = ~empty;
  assign m_data = mem_q[rd_q[AW-1:0]][DW-1:0];
  assign m_ch = mem_q[rd_q[AW-1:0]][WW-1:DW];
  assign overflow = push_q & full & ~pop;
  assign frame_err = ferr_q;
  assign start = 1'b1;
  assign pd = 1'b1;
  assign cs_n = 1'b0;
endmodule

// File: tb/tb_adc_serial_rx_mc.sv
// tb_adc_serial_rx_mc: directed frame stimulus on the ADC pins with hand-computed expected samples
module tb_adc_serial_rx_mc;
  logic clk = 1'b0;
  logic rst, en, sck, fsync, din, m_ready;
  logic [23:0] m_data;
  logic [0:0] m_ch;
  logic m_valid, overflow, frame_err, start, pd, cs_n;
  logic [31:0] got[$];
  int n_cmp = 0, n_err = 0, ovf_cnt = 0, ferr_cnt = 0, ovf0, ferr0;

  adc_serial_rx_mc dut (
    .clk(clk), .rst(rst), .en(en), .sck(sck), .fsync(fsync), .din(din),
    .m_data(m_data), .m_ch(m_ch), .m_valid(m_valid), .m_ready(m_ready),
    .overflow(overflow), .frame_err(frame_err), .start(start), .pd(pd), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_valid && m_ready) got.push_back({7'd0, m_ch, m_data});
    if (overflow) ovf_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  task automatic expect_pop(input string tag, input logic ch, input logic [23:0] d);
    logic [31:0] g;
    g = (got.size() > 0) ? got.pop_front() : 32'hxxxxxxxx;
    chk(tag, g, {7'd0, ch, d});
  endtask

  task automatic send_bit(input logic fs, input logic d);
    repeat (4) @(posedge clk);
    #1 sck = 1'b0; fsync = fs; din = d;
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
  endtask

  task automatic send_slot(input logic fs, input logic [23:0] d, input int nbits);
    logic [31:0] w;
    w = {d, 8'h00};
    for (int i = 0; i < nbits; i++) send_bit(fs && i == 0, w[31-i]);
  endtask

  task automatic send_frame(input logic [23:0] d0, input logic [23:0] d1);
    send_slot(1'b1, d0, 32);
    send_slot(1'b0, d1, 32);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] bp0 [5] = '{24'hA1A1A1, 24'hA2A2A2, 24'hA3A3A3, 24'hA4A4A4, 24'hA5A5A5};
    logic [23:0] bp1 [5] = '{24'hB1B1B1, 24'hB2B2B2, 24'hB3B3B3, 24'hB4B4B4, 24'hB5B5B5};
    rst = 1'b1; en = 1'b0; sck = 1'b0; fsync = 1'b0; din = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {8'd0, m_data}, 32'd0);
    chk("rst_ch", {31'd0, m_ch}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("const_pins", {29'd0, start, pd, cs_n}, 32'd6);
    en = 1'b1;

    ovf0 = ovf_cnt; ferr0 = ferr_cnt;
    send_frame(24'hABCDEF, 24'h123456);
    idle(2);
    expect_pop("nom_s0", 1'b0, 24'hABCDEF);
    expect_pop("nom_s1", 1'b1, 24'h123456);
    chk("nom_extra", got.size(), 0);
    chk("nom_ovf", ovf_cnt - ovf0, 0);
    chk("nom_ferr", ferr_cnt - ferr0, 0);

    m_ready = 1'b0;
    ovf0 = ovf_cnt; ferr0 = ferr_cnt;
    for (int f = 0; f < 5; f++) begin
      send_frame(bp0[f], bp1[f]);
      if (f == 2) begin
        repeat (10) @(posedge clk);
        #1 chk("bp_hold_mid", {7'd0, m_ch, m_data}, {8'd0, 24'hA1A1A1});
      end
    end
    idle(2);
    chk("bp_ovf", ovf_cnt - ovf0, 6);
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_hold_end", {7'd0, m_ch, m_data}, {8'd0, 24'hA1A1A1});
    chk("bp_no_pop", got.size(), 0);
    m_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    expect_pop("bp_d0", 1'b0, 24'hA1A1A1);
    expect_pop("bp_d1", 1'b1, 24'hB1B1B1);
    expect_pop("bp_d2", 1'b0, 24'hA2A2A2);
    expect_pop("bp_d3", 1'b1, 24'hB2B2B2);
    chk("bp_extra", got.size(), 0);
    chk("bp_ferr", ferr_cnt - ferr0, 0);

    ovf0 = ovf_cnt; ferr0 = ferr_cnt;
    send_slot(1'b1, 24'hC0FFEE, 32);
    send_slot(1'b0, 24'hDDDDDD, 8);
    send_frame(24'h654321, 24'h0F0F0F);
    idle(2);
    chk("efs_ferr", ferr_cnt - ferr0, 1);
    expect_pop("efs_s0", 1'b0, 24'hC0FFEE);
    expect_pop("efs_n0", 1'b0, 24'h654321);
    expect_pop("efs_n1", 1'b1, 24'h0F0F0F);
    chk("efs_extra", got.size(), 0);

    m_ready = 1'b0;
    ovf0 = ovf_cnt;
    send_frame(24'h0C0001, 24'h0C0002);
    send_frame(24'h0C0003, 24'h0C0004);
    idle(2);
    send_slot(1'b1, 24'h0C0005, 32);
    repeat (4) @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pp_ovf", ovf_cnt - ovf0, 0);
    chk("pp_head", {7'd0, m_ch, m_data}, {8'd1, 24'h0C0002});
    m_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    expect_pop("pp_d0", 1'b0, 24'h0C0001);
    expect_pop("pp_d1", 1'b1, 24'h0C0002);
    expect_pop("pp_d2", 1'b0, 24'h0C0003);
    expect_pop("pp_d3", 1'b1, 24'h0C0004);
    expect_pop("pp_d4", 1'b0, 24'h0C0005);
    chk("pp_extra", got.size(), 0);
    send_slot(1'b0, 24'h0C0006, 32);
    idle(2);
    expect_pop("pp_d5", 1'b1, 24'h0C0006);

    ovf0 = ovf_cnt; ferr0 = ferr_cnt;
    send_slot(1'b1, 24'hE1E1E1, 32);
    send_slot(1'b0, 24'hE2E2E2, 10);
    en = 1'b0;
    for (int i = 0; i < 22; i++) send_bit(1'b0, i[0]);
    en = 1'b1;
    idle(2);
    send_frame(24'hE3E3E3, 24'hE4E4E4);
    idle(2);
    expect_pop("en_s0", 1'b0, 24'hE1E1E1);
    expect_pop("en_n0", 1'b0, 24'hE3E3E3);
    expect_pop("en_n1", 1'b1, 24'hE4E4E4);
    chk("en_extra", got.size(), 0);
    chk("en_ferr", ferr_cnt - ferr0, 0);

    m_ready = 1'b0;
    send_slot(1'b1, 24'hD1D1D1, 32);
    send_slot(1'b0, 24'hD2D2D2, 8);
    chk("mr_pre_valid", {31'd0, m_valid}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mr_valid", {31'd0, m_valid}, 32'd0);
    chk("mr_data", {7'd0, m_ch, m_data}, 32'd0);
    chk("mr_flags", {30'd0, overflow, frame_err}, 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 56; i++) send_bit(1'b0, i[1]);
    idle(2);
    chk("mr_inflight", got.size(), 0);
    send_frame(24'hD3D3D3, 24'hD4D4D4);
    idle(2);
    expect_pop("mr_n0", 1'b0, 24'hD3D3D3);
    expect_pop("mr_n1", 1'b1, 24'hD4D4D4);
    chk("mr_extra", got.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
